bcd_display_formatter: RTL

- Downstream stage of the interpolation/lookup FSM. Takes a 14-bit binary result (found y or interpolated y) and converts it to four BCD digit codes for SS_Driver digit0..digit3.
- Replaces the multi-cycle divide/subtract display path with an iterative double-dabble converter behind a start/done handshake.
- Adds saturation and optional leading-zero blanking.

---
 rtl/bcd_display_formatter_if.sv | 24 ++
 rtl/bcd_display_formatter.sv | 117 +++++++++++
 2 files changed

// File: rtl/bcd_display_formatter_if.sv
// Start/done handshake and digit-code bus between the lookup FSM and the display formatter.
interface bcd_display_formatter_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [4:0]       digit0;
  logic [4:0]       digit1;
  logic [4:0]       digit2;
  logic [4:0]       digit3;

  modport master (
    output start, value,
    input  busy, done, overflow, digit0, digit1, digit2, digit3
  );

  modport slave (
    input  start, value,
    output busy, done, overflow, digit0, digit1, digit2, digit3
  );
endinterface

// File: rtl/bcd_display_formatter.sv
// Iterative double-dabble binary-to-BCD converter feeding SS_Driver digit codes,
// with saturation at MAX_VALUE and optional leading-zero blanking.
module bcd_display_formatter #(
  parameter int         WIDTH      = 14,
  parameter int         MAX_VALUE  = 9999,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [4:0] BLANK_CODE = 5'd31
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_display_formatter_if.slave  bus
);

  localparam int               CW    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, BLANK, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] v_q, bin_q;
  logic [15:0]      bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_next_q, ovf_q, busy_q, done_q;
  logic [3:0][4:0]  dig_q;

  logic [15:0]      adj;
  logic [15:0]      bcd_d;
  logic [WIDTH-1:0] bin_d;
  logic [3:0][4:0]  code;
  logic             lz;

  // add-3 correction per nibble before each shift
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
  end

  assign bcd_d = {adj[14:0], bin_q[WIDTH-1]};
  assign bin_d = {bin_q[WIDTH-2:0], 1'b0};

  // leading-zero run from the thousands digit; the units digit always shows
  always_comb begin
    lz   = 1'b1;
    code = '0;
    for (int i = 3; i >= 0; i--) begin
      lz      = lz && (bcd_q[4*i +: 4] == 4'd0) && (i != 0);
      code[i] = (BLANK_LZ && lz) ? BLANK_CODE : {1'b0, bcd_q[4*i +: 4]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      v_q        <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dig_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            v_q     <= bus.value;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (v_q > MAX_W) begin
            ovf_next_q <= 1'b1;
            bin_q      <= MAX_W;
          end else begin
            ovf_next_q <= 1'b0;
            bin_q      <= v_q;
          end
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (cnt_q == LAST) begin
            state_q <= BLANK;
          end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BLANK: begin
          dig_q   <= code;
          ovf_q   <= ovf_next_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.digit0   = dig_q[0];
  assign bus.digit1   = dig_q[1];
  assign bus.digit2   = dig_q[2];
  assign bus.digit3   = dig_q[3];

endmodule
